qeciphy_rx_frame_sync: RTL and testbench
========================================

Name: qeciphy_rx_frame_sync

Overview:
- Receive-side frame synchroniser, directly upstream of qeciphy_rx_monitor.
- Watches the raw 64-bit word stream, finds the frame alignment word (FAW) and confirms lock.
- Once locked, regenerates the 64-word frame cadence on faw_boundary_o / crc_boundary_o, word-aligned with tdata_o.
- Frame layout: FAW word, then 9 groups of (6 data words + 1 CRC word), 64 words total.

Parameters:
- FAW_WORD, 64'hD1CE_FA11_0A1E_5EED, exact 64-bit value identifying a FAW word.
- LOCK_COUNT, 3, consecutive FAW matches at frame position 0 needed to lock; legal 1..15.
- UNLOCK_COUNT, 4, consecutive FAW misses at position 0 that drop lock; legal 1..15.

Ports:
- clk_i  in  1  clock; every cycle carries one word.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  sync enable; low forces SEARCH.
- tdata_i  in  64  raw receive word.
- tdata_o  out  64  tdata_i delayed one cycle.
- faw_boundary_o  out  1  tdata_o is a FAW word of a locked frame.
- crc_boundary_o  out  1  tdata_o is a CRC word of a locked frame.
- locked_o  out  1  frame lock held; drives the monitor's enable_i.
- lock_lost_o  out  1  one-cycle pulse on LOCKED->SEARCH.

Behaviour:

Reset (rst_n_i low, async):
- All outputs 0, tdata_o = 0.
- State SEARCH; pos = 0; match_cnt = 0; miss_cnt = 0.

Latency:
- All outputs are registered, one-cycle latency.
- Boundary flags always qualify the word currently on tdata_o.

Position counter:
- pos is 6 bits, increments every cycle, wraps 63->0.
- CRC slot: pos != 0 and pos mod 7 == 0, i.e. pos 7,14,...,63.
- Use a mod-7 sub-counter; no divider.

State SEARCH:
- On tdata_i == FAW_WORD: this word becomes pos 0, match_cnt = 1.
  - Go to VERIFY, or go directly to LOCKED if LOCK_COUNT == 1.
- Otherwise pos is don't-care; no boundaries emitted.

State VERIFY:
- Checked only at pos 0.
- Match: match_cnt++. On reaching LOCK_COUNT, go to LOCKED and emit a FAW boundary for that word.
- Miss: go to SEARCH with match_cnt = 0. The same word is not re-evaluated as a FAW candidate.
- Words at non-zero positions are ignored, including FAW look-alikes.

State LOCKED:
- faw_boundary_o = 1 for every pos-0 word that does not cause lock loss, whether it matched or not.
- crc_boundary_o = 1 at CRC slots.
- Match at pos 0 clears miss_cnt.
- Miss at pos 0 increments miss_cnt. On reaching UNLOCK_COUNT:
  - go to SEARCH;
  - emit no FAW boundary for that word;
  - pulse lock_lost_o;
  - clear locked_o with the same registered update.
- Lock is only ever lost at pos 0. Every emitted FAW boundary is therefore followed by the complete 63-word CRC cadence.

Invariants:
- faw_boundary_o and crc_boundary_o are never both 1.
- No crc_boundary_o before the first faw_boundary_o after lock.
- locked_o = 1 on the same output cycle as the first faw_boundary_o.

enable_i low:
- Synchronous, takes priority over everything.
- Next state SEARCH; counters cleared; boundaries and locked_o 0.
- tdata_o still follows tdata_i.
- If leaving LOCKED this way, lock_lost_o still pulses.

Reset mid-frame:
- Immediate return to reset values.
- Lock is re-acquired from scratch after release.

Test Plan:
1. Clean frames, FAW_WORD every 64 words from cycle 10, defaults -> locked_o rises with faw_boundary_o on tdata_o of the 3rd FAW (input cycle 138, output cycle 139); then crc_boundary_o at output offsets 7,14,...,63 and faw_boundary_o every 64 cycles.
2. Locked, then corrupt the FAW in 3 consecutive frames, then restore -> faw_boundary_o still asserted on the corrupted words; lock held; miss_cnt clears on the good FAW.
3. Locked, then corrupt 4 consecutive FAWs -> no faw_boundary_o on the 4th; lock_lost_o pulses once; locked_o falls the same cycle; no further boundaries until relock.
4. SEARCH with FAW_WORD injected at offset 20 inside frame data, true FAW every 64 -> VERIFY fails at the false alignment and returns to SEARCH; lock ends on the true cadence; no boundary emitted before lock.
5. Locked, enable_i low for 1 cycle at pos 30 -> locked_o falls, lock_lost_o pulses, no crc at pos 35; relocks after 3 further FAWs.
6. rst_n_i asserted asynchronously mid-clock at pos 40 while locked -> all outputs 0 immediately; LOCK_COUNT=1 variant relocks on the first FAW after release.

Source files
------------

// File: rtl/qeciphy_rx_frame_sync.sv
// Receive-side frame synchroniser.
// Hunts for the frame alignment word (FAW) in the raw 64-bit word stream and
// confirms it over several frames before declaring lock. While locked it
// regenerates the 64-word frame cadence: one FAW word, then nine groups of
// six data words plus one CRC word. The boundary flags are registered
// alongside the delayed data, so each flag always describes the word that is
// currently on tdata_o.
module qeciphy_rx_frame_sync #(
    parameter logic [63:0] FAW_WORD     = 64'hD1CE_FA11_0A1E_5EED,
    parameter int unsigned LOCK_COUNT   = 3,
    parameter int unsigned UNLOCK_COUNT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic [63:0] tdata_i,
    output logic [63:0] tdata_o,
    output logic        faw_boundary_o,
    output logic        crc_boundary_o,
    output logic        locked_o,
    output logic        lock_lost_o
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_CNT_C = 4'(UNLOCK_COUNT);

    // A CRC slot is any non-zero position that is a multiple of seven.
    // The mod-7 sub-counter supplies the residue, so no divider is needed.
    function automatic logic is_crc_slot(input logic [5:0] pos, input logic [2:0] mod7);
        return (pos != 6'd0) && (mod7 == 3'd0);
    endfunction

    // Advance the mod-7 residue alongside the position counter. 63 is a
    // multiple of 7, so the residue also returns to 0 when pos wraps.
    function automatic logic [2:0] next_mod7(input logic [5:0] pos, input logic [2:0] mod7);
        logic [2:0] res;
        if (pos == 6'd63) begin
            res = 3'd0;
        end else if (mod7 == 3'd6) begin
            res = 3'd0;
        end else begin
            res = mod7 + 3'd1;
        end
        return res;
    endfunction

    // pos_r / mod7_r describe the word currently presented on tdata_i.
    state_t      state_r;
    logic [5:0]  pos_r;
    logic [2:0]  mod7_r;
    logic [3:0]  match_cnt_r;
    logic [3:0]  miss_cnt_r;

    logic [63:0] tdata_r;
    logic        faw_r;
    logic        crc_r;
    logic        locked_r;
    logic        lost_r;

    state_t      state_nxt_s;
    logic [5:0]  pos_nxt_s;
    logic [2:0]  mod7_nxt_s;
    logic [3:0]  match_nxt_s;
    logic [3:0]  miss_nxt_s;
    logic        faw_nxt_s;
    logic        crc_nxt_s;
    logic        locked_nxt_s;
    logic        lost_nxt_s;
    logic        faw_hit_s;
    logic        at_pos0_s;

    assign faw_hit_s = (tdata_i == FAW_WORD);
    assign at_pos0_s = (pos_r == 6'd0);

    // Next-state, counter and boundary-flag decode for the word on tdata_i.
    always_comb begin
        state_nxt_s = state_r;
        pos_nxt_s   = pos_r + 6'd1;
        mod7_nxt_s  = next_mod7(pos_r, mod7_r);
        match_nxt_s = match_cnt_r;
        miss_nxt_s  = miss_cnt_r;
        faw_nxt_s   = 1'b0;
        crc_nxt_s   = 1'b0;

        if (!enable_i) begin
            state_nxt_s = ST_SEARCH;
            pos_nxt_s   = 6'd0;
            mod7_nxt_s  = 3'd0;
            match_nxt_s = 4'd0;
            miss_nxt_s  = 4'd0;
        end else begin
            case (state_r)
                ST_SEARCH: begin
                    miss_nxt_s = 4'd0;
                    if (faw_hit_s) begin
                        // This word is position 0, so the next one is position 1.
                        pos_nxt_s   = 6'd1;
                        mod7_nxt_s  = 3'd1;
                        match_nxt_s = 4'd1;
                        if (LOCK_CNT_C == 4'd1) begin
                            state_nxt_s = ST_LOCKED;
                            faw_nxt_s   = 1'b1;
                            match_nxt_s = 4'd0;
                        end else begin
                            state_nxt_s = ST_VERIFY;
                        end
                    end else begin
                        pos_nxt_s   = 6'd0;
                        mod7_nxt_s  = 3'd0;
                        match_nxt_s = 4'd0;
                    end
                end

                ST_VERIFY: begin
                    // Only position 0 is examined; look-alikes elsewhere are data.
                    if (at_pos0_s) begin
                        if (faw_hit_s) begin
                            if ((match_cnt_r + 4'd1) == LOCK_CNT_C) begin
                                state_nxt_s = ST_LOCKED;
                                faw_nxt_s   = 1'b1;
                                match_nxt_s = 4'd0;
                                miss_nxt_s  = 4'd0;
                            end else begin
                                match_nxt_s = match_cnt_r + 4'd1;
                            end
                        end else begin
                            // The failing word is not reconsidered as a new candidate.
                            state_nxt_s = ST_SEARCH;
                            pos_nxt_s   = 6'd0;
                            mod7_nxt_s  = 3'd0;
                            match_nxt_s = 4'd0;
                        end
                    end else begin
                        match_nxt_s = match_cnt_r;
                    end
                end

                ST_LOCKED: begin
                    crc_nxt_s = is_crc_slot(pos_r, mod7_r);
                    if (at_pos0_s) begin
                        if (faw_hit_s) begin
                            miss_nxt_s = 4'd0;
                            faw_nxt_s  = 1'b1;
                        end else if ((miss_cnt_r + 4'd1) == UNLOCK_CNT_C) begin
                            // Lock drops here, so this word gets no FAW flag.
                            state_nxt_s = ST_SEARCH;
                            pos_nxt_s   = 6'd0;
                            mod7_nxt_s  = 3'd0;
                            miss_nxt_s  = 4'd0;
                            match_nxt_s = 4'd0;
                        end else begin
                            miss_nxt_s = miss_cnt_r + 4'd1;
                            faw_nxt_s  = 1'b1;
                        end
                    end else begin
                        miss_nxt_s = miss_cnt_r;
                    end
                end

                default: begin
                    state_nxt_s = ST_SEARCH;
                    pos_nxt_s   = 6'd0;
                    mod7_nxt_s  = 3'd0;
                    match_nxt_s = 4'd0;
                    miss_nxt_s  = 4'd0;
                end
            endcase
        end

        locked_nxt_s = (state_nxt_s == ST_LOCKED);
        lost_nxt_s   = (state_r == ST_LOCKED) && (state_nxt_s != ST_LOCKED);
    end

    // Frame state and alignment counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= ST_SEARCH;
            pos_r       <= 6'd0;
            mod7_r      <= 3'd0;
            match_cnt_r <= 4'd0;
            miss_cnt_r  <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            pos_r       <= pos_nxt_s;
            mod7_r      <= mod7_nxt_s;
            match_cnt_r <= match_nxt_s;
            miss_cnt_r  <= miss_nxt_s;
        end
    end

    // Output register: delayed data with the flags that qualify it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tdata_r  <= 64'd0;
            faw_r    <= 1'b0;
            crc_r    <= 1'b0;
            locked_r <= 1'b0;
            lost_r   <= 1'b0;
        end else begin
            tdata_r  <= tdata_i;
            faw_r    <= faw_nxt_s;
            crc_r    <= crc_nxt_s;
            locked_r <= locked_nxt_s;
            lost_r   <= lost_nxt_s;
        end
    end

    assign tdata_o        = tdata_r;
    assign faw_boundary_o = faw_r;
    assign crc_boundary_o = crc_r;
    assign locked_o       = locked_r;
    assign lock_lost_o    = lost_r;

endmodule

// File: tb/tb_qeciphy_rx_frame_sync.sv
// Directed bench for qeciphy_rx_frame_sync. Two instances share the stimulus:
// one with default parameters and one with LOCK_COUNT=1.
module tb_qeciphy_rx_frame_sync;

    localparam logic [63:0] FAW = 64'hD1CE_FA11_0A1E_5EED;
    localparam int BASE = 10;

    logic        clk_i    = 1'b0;
    logic        rst_n_i  = 1'b0;
    logic        enable_i = 1'b0;
    logic [63:0] tdata_i  = 64'd0;

    logic [63:0] tdata_o, tdata_o2;
    logic        faw_o, crc_o, locked_o, lost_o;
    logic        faw_o2, crc_o2, locked_o2, lost_o2;

    int n_checks = 0;
    int n_fail   = 0;
    int gcyc     = 0;

    always #5 clk_i = ~clk_i;

    qeciphy_rx_frame_sync dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .tdata_i(tdata_i),
        .tdata_o(tdata_o), .faw_boundary_o(faw_o), .crc_boundary_o(crc_o),
        .locked_o(locked_o), .lock_lost_o(lost_o)
    );

    qeciphy_rx_frame_sync #(.LOCK_COUNT(1)) dut_lc1 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .tdata_i(tdata_i),
        .tdata_o(tdata_o2), .faw_boundary_o(faw_o2), .crc_boundary_o(crc_o2),
        .locked_o(locked_o2), .lock_lost_o(lost_o2)
    );

    function automatic logic [63:0] data_word(input int c);
        return {32'hDA7A_0000, 32'(c)};
    endfunction

    function automatic bit slot(input int off);
        return (off != 0) && ((off % 7) == 0);
    endfunction

    task automatic drive(input logic [63:0] w);
        tdata_i = w;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_n_i  = 1'b0;
        enable_i = 1'b1;
        tdata_i  = FAW;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++; if (tdata_o !== 64'd0) begin n_fail++; $display("FAIL reset tdata_o got %h exp 0", tdata_o); end
        n_checks++; if (faw_o !== 1'b0) begin n_fail++; $display("FAIL reset faw got %b exp 0", faw_o); end
        n_checks++; if (crc_o !== 1'b0) begin n_fail++; $display("FAIL reset crc got %b exp 0", crc_o); end
        n_checks++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL reset locked got %b exp 0", locked_o); end
        n_checks++; if (lost_o !== 1'b0) begin n_fail++; $display("FAIL reset lost got %b exp 0", lost_o); end
        n_checks++; if (locked_o2 !== 1'b0 || tdata_o2 !== 64'd0) begin n_fail++; $display("FAIL reset lc1 locked %b tdata %h exp 0", locked_o2, tdata_o2); end
    endtask

    // Clean frames, FAW every 64 words from cycle 10; lock on the 3rd FAW (input 138).
    task automatic test_clean_lock;
        logic [63:0] w;
        logic e_lock, e_faw, e_crc;
        int off;
        rst_n_i = 1'b1;
        for (int c = 0; c < BASE + 4 * 64; c++) begin
            off = c - BASE;
            w = (c >= BASE && (off % 64) == 0) ? FAW : data_word(c);
            drive(w);
            e_lock = (c >= 138);
            e_faw  = e_lock && ((off % 64) == 0);
            e_crc  = (c > 138) && slot(off % 64);
            n_checks++; if (tdata_o !== w) begin n_fail++; $display("FAIL clean tdata c=%0d got %h exp %h", c, tdata_o, w); end
            n_checks++; if (locked_o !== e_lock) begin n_fail++; $display("FAIL clean locked c=%0d got %b exp %b", c, locked_o, e_lock); end
            n_checks++; if (faw_o !== e_faw) begin n_fail++; $display("FAIL clean faw c=%0d got %b exp %b", c, faw_o, e_faw); end
            n_checks++; if (crc_o !== e_crc) begin n_fail++; $display("FAIL clean crc c=%0d got %b exp %b", c, crc_o, e_crc); end
            n_checks++; if (lost_o !== 1'b0) begin n_fail++; $display("FAIL clean lost c=%0d got %b exp 0", c, lost_o); end
            n_checks++; if (locked_o2 !== (c >= BASE)) begin n_fail++; $display("FAIL clean lc1 locked c=%0d got %b exp %b", c, locked_o2, (c >= BASE)); end
        end
        gcyc = BASE + 4 * 64;
    endtask

    // Three corrupted FAWs, one good, three corrupted, one good: lock held throughout.
    task automatic test_corrupt_hold;
        logic [63:0] w;
        for (int j = 0; j < 8; j++) begin
            for (int off = 0; off < 64; off++) begin
                if (off == 0) w = ((j % 4) != 3) ? (FAW ^ 64'h0000_0000_0000_0001) : FAW;
                else          w = data_word(gcyc);
                drive(w);
                n_checks++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL hold locked j=%0d off=%0d got %b exp 1", j, off, locked_o); end
                n_checks++; if (faw_o !== (off == 0)) begin n_fail++; $display("FAIL hold faw j=%0d off=%0d got %b exp %b", j, off, faw_o, (off == 0)); end
                n_checks++; if (crc_o !== slot(off)) begin n_fail++; $display("FAIL hold crc j=%0d off=%0d got %b exp %b", j, off, crc_o, slot(off)); end
                n_checks++; if (lost_o !== 1'b0) begin n_fail++; $display("FAIL hold lost j=%0d off=%0d got %b exp 0", j, off, lost_o); end
                gcyc++;
            end
        end
    endtask

    // Four corrupted FAWs drop lock at the 4th; relock after three clean FAWs.
    task automatic test_lock_loss;
        logic [63:0] w;
        logic e_lock, e_faw, e_crc, e_lost, e_lock2;
        for (int j = 0; j < 7; j++) begin
            for (int off = 0; off < 64; off++) begin
                if (off == 0) w = (j < 4) ? (FAW ^ 64'hFF00_0000_0000_0000) : FAW;
                else          w = data_word(gcyc);
                drive(w);
                e_lock  = (j < 3) || (j >= 6);
                e_faw   = (off == 0) && e_lock;
                e_crc   = slot(off) && e_lock;
                e_lost  = (j == 3) && (off == 0);
                e_lock2 = (j < 3) || (j >= 4);
                n_checks++; if (locked_o !== e_lock) begin n_fail++; $display("FAIL loss locked j=%0d off=%0d got %b exp %b", j, off, locked_o, e_lock); end
                n_checks++; if (faw_o !== e_faw) begin n_fail++; $display("FAIL loss faw j=%0d off=%0d got %b exp %b", j, off, faw_o, e_faw); end
                n_checks++; if (crc_o !== e_crc) begin n_fail++; $display("FAIL loss crc j=%0d off=%0d got %b exp %b", j, off, crc_o, e_crc); end
                n_checks++; if (lost_o !== e_lost) begin n_fail++; $display("FAIL loss lost j=%0d off=%0d got %b exp %b", j, off, lost_o, e_lost); end
                n_checks++; if (locked_o2 !== e_lock2) begin n_fail++; $display("FAIL loss lc1 locked j=%0d off=%0d got %b exp %b", j, off, locked_o2, e_lock2); end
                gcyc++;
            end
        end
    endtask

    // enable_i low for one cycle at position 30 while locked.
    task automatic test_enable_drop;
        logic [63:0] w;
        logic e_lock, e_faw, e_crc, e_lost, e_lock2;
        for (int j = 0; j < 4; j++) begin
            for (int off = 0; off < 64; off++) begin
                w = (off == 0) ? FAW : data_word(gcyc);
                enable_i = !((j == 0) && (off == 30));
                drive(w);
                enable_i = 1'b1;
                e_lock  = ((j == 0) && (off < 30)) || (j >= 3);
                e_faw   = (off == 0) && e_lock;
                e_crc   = slot(off) && e_lock;
                e_lost  = (j == 0) && (off == 30);
                e_lock2 = ((j == 0) && (off < 30)) || (j >= 1);
                n_checks++; if (tdata_o !== w) begin n_fail++; $display("FAIL en tdata j=%0d off=%0d got %h exp %h", j, off, tdata_o, w); end
                n_checks++; if (locked_o !== e_lock) begin n_fail++; $display("FAIL en locked j=%0d off=%0d got %b exp %b", j, off, locked_o, e_lock); end
                n_checks++; if (faw_o !== e_faw) begin n_fail++; $display("FAIL en faw j=%0d off=%0d got %b exp %b", j, off, faw_o, e_faw); end
                n_checks++; if (crc_o !== e_crc) begin n_fail++; $display("FAIL en crc j=%0d off=%0d got %b exp %b", j, off, crc_o, e_crc); end
                n_checks++; if (lost_o !== e_lost) begin n_fail++; $display("FAIL en lost j=%0d off=%0d got %b exp %b", j, off, lost_o, e_lost); end
                n_checks++; if (locked_o2 !== e_lock2 || lost_o2 !== e_lost) begin n_fail++; $display("FAIL en lc1 j=%0d off=%0d locked %b lost %b exp %b %b", j, off, locked_o2, lost_o2, e_lock2, e_lost); end
                gcyc++;
            end
        end
    endtask

    // Async reset mid-clock at position 40, then relock from scratch.
    task automatic test_async_reset;
        logic [63:0] w;
        logic e_lock, e_lock2, e_faw2, e_crc2;
        for (int off = 0; off < 40; off++) begin
            w = (off == 0) ? FAW : data_word(gcyc);
            drive(w);
            gcyc++;
        end
        n_checks++; if (locked_o !== 1'b1 || locked_o2 !== 1'b1) begin n_fail++; $display("FAIL arst pre locked got %b %b exp 1 1", locked_o, locked_o2); end
        tdata_i = data_word(gcyc);
        #3;
        rst_n_i = 1'b0;
        #1;
        n_checks++; if (tdata_o !== 64'd0 || tdata_o2 !== 64'd0) begin n_fail++; $display("FAIL arst tdata got %h %h exp 0", tdata_o, tdata_o2); end
        n_checks++; if (locked_o !== 1'b0 || locked_o2 !== 1'b0) begin n_fail++; $display("FAIL arst locked got %b %b exp 0", locked_o, locked_o2); end
        n_checks++; if (faw_o !== 1'b0 || crc_o !== 1'b0 || lost_o !== 1'b0) begin n_fail++; $display("FAIL arst flags got %b%b%b exp 000", faw_o, crc_o, lost_o); end
        n_checks++; if (faw_o2 !== 1'b0 || crc_o2 !== 1'b0 || lost_o2 !== 1'b0) begin n_fail++; $display("FAIL arst lc1 flags got %b%b%b exp 000", faw_o2, crc_o2, lost_o2); end
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (locked_o !== 1'b0 || tdata_o !== 64'd0) begin n_fail++; $display("FAIL arst held locked %b tdata %h exp 0", locked_o, tdata_o); end
        rst_n_i = 1'b1;
        for (int c = 0; c < 141; c++) begin
            w = (c >= 5 && ((c - 5) % 64) == 0) ? FAW : data_word(c + 5000);
            drive(w);
            e_lock  = (c >= 133);
            e_lock2 = (c >= 5);
            e_faw2  = (c >= 5) && (((c - 5) % 64) == 0);
            e_crc2  = (c > 5) && slot((c - 5) % 64);
            n_checks++; if (locked_o !== e_lock) begin n_fail++; $display("FAIL relock locked c=%0d got %b exp %b", c, locked_o, e_lock); end
            n_checks++; if (faw_o !== (c == 133)) begin n_fail++; $display("FAIL relock faw c=%0d got %b exp %b", c, faw_o, (c == 133)); end
            n_checks++; if (locked_o2 !== e_lock2) begin n_fail++; $display("FAIL relock lc1 locked c=%0d got %b exp %b", c, locked_o2, e_lock2); end
            n_checks++; if (faw_o2 !== e_faw2) begin n_fail++; $display("FAIL relock lc1 faw c=%0d got %b exp %b", c, faw_o2, e_faw2); end
            n_checks++; if (crc_o2 !== e_crc2) begin n_fail++; $display("FAIL relock lc1 crc c=%0d got %b exp %b", c, crc_o2, e_crc2); end
        end
    endtask

    // False FAW at offset 20 inside data; true FAW every 64 from cycle 64.
    task automatic test_false_faw;
        logic [63:0] w;
        logic e_lock, e_faw, e_crc;
        rst_n_i = 1'b0;
        drive(data_word(9999));
        rst_n_i = 1'b1;
        for (int c = 0; c < 256 + 64; c++) begin
            w = ((c == 20) || (c >= 64 && (c % 64) == 0)) ? FAW : data_word(c + 7000);
            drive(w);
            e_lock = (c >= 256);
            e_faw  = e_lock && ((c % 64) == 0);
            e_crc  = (c > 256) && slot(c % 64);
            n_checks++; if (locked_o !== e_lock) begin n_fail++; $display("FAIL false locked c=%0d got %b exp %b", c, locked_o, e_lock); end
            n_checks++; if (faw_o !== e_faw) begin n_fail++; $display("FAIL false faw c=%0d got %b exp %b", c, faw_o, e_faw); end
            n_checks++; if (crc_o !== e_crc) begin n_fail++; $display("FAIL false crc c=%0d got %b exp %b", c, crc_o, e_crc); end
            n_checks++; if (lost_o !== 1'b0) begin n_fail++; $display("FAIL false lost c=%0d got %b exp 0", c, lost_o); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_corrupt_hold();
        test_lock_loss();
        test_enable_drop();
        test_async_reset();
        test_false_faw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
